sd_init: RTL



---
 rtl/sd_init.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sd_init.sv
// sd_init: SPI-mode SD card power-up, CMD0/CMD8 and CMD55/ACMD41 sequencer.
// MISO is captured on the SD_CK rise; state and card pins move on the fall.
module sd_init #(
  parameter int PWRUP_CLKS     = 80,
  parameter int RESP_TIMEOUT   = 128,
  parameter int ACMD41_RETRIES = 1023,
  parameter int GAP_CLKS       = 8
) (
  input  logic       SD_CK,
  input  logic       rst,
  input  logic       start,
  input  logic       SD_MISO,
  output logic       SD_MOSI,
  output logic       SD_CSn,
  output logic       init_o,
  output logic       init_err,
  output logic [2:0] err_code,
  output logic       card_v2
);

  localparam int TMAX_PT = (PWRUP_CLKS > RESP_TIMEOUT) ?
                           PWRUP_CLKS : RESP_TIMEOUT;
  localparam int TMAX    = (TMAX_PT > GAP_CLKS) ? TMAX_PT : GAP_CLKS;
  localparam int TW      = $clog2(TMAX + 1);
  localparam int RW      = $clog2(ACMD41_RETRIES + 1);

  localparam logic [TW-1:0] PW_LD = TW'(PWRUP_CLKS - 1);
  localparam logic [TW-1:0] GP_LD = TW'(GAP_CLKS - 1);
  localparam logic [TW-1:0] TO_LD = TW'(RESP_TIMEOUT);
  localparam logic [RW-1:0] RT_LD = RW'(ACMD41_RETRIES);

  typedef enum logic [3:0] {
    S_IDLE,
    S_PWRUP,
    S_SEND,
    S_WAIT,
    S_R1,
    S_R7,
    S_GAP,
    S_DONE,
    S_FAIL
  } state_t;

  typedef enum logic [1:0] {
    C_0,
    C_8,
    C_55,
    C_41
  } cmd_t;

  state_t        state;
  cmd_t          cmd;
  logic [5:0]    bcnt;
  logic [TW-1:0] tmr;
  logic [RW-1:0] retry;
  logic [30:0]   sr;
  logic          miso_q;
  logic [47:0]   word;
  logic [7:0]    r1;
  logic [31:0]   r7;

  assign r1 = {sr[6:0], miso_q};
  assign r7 = {sr[30:0], miso_q};

  // Frame of the command currently being shifted out.
  always_comb begin
    word = 48'h400000000095;
    unique case (cmd)
      C_0:  word = 48'h400000000095;
      C_8:  word = 48'h48000001AA87;
      C_55: word = 48'h770000000065;
      C_41: word = card_v2 ? 48'h694000000077
                           : 48'h6900000000E5;
      default: word = 48'h400000000095;
    endcase
  end

  // Card data is stable around the rising edge, so capture it there.
  always_ff @(posedge SD_CK) begin
    if (rst) miso_q <= 1'b1;
    else     miso_q <= SD_MISO;
  end

  // Sequencer: every command starts with a 0 start bit on MOSI.
  always_ff @(negedge SD_CK) begin
    if (rst) begin
      state    <= S_IDLE;
      cmd      <= C_0;
      bcnt     <= '0;
      tmr      <= '0;
      retry    <= '0;
      sr       <= '0;
      SD_MOSI  <= 1'b1;
      SD_CSn   <= 1'b1;
      init_o   <= 1'b0;
      init_err <= 1'b0;
      err_code <= 3'd0;
      card_v2  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            state    <= S_PWRUP;
            cmd      <= C_0;
            tmr      <= PW_LD;
            retry    <= RT_LD;
            SD_CSn   <= 1'b1;
            SD_MOSI  <= 1'b1;
            init_o   <= 1'b0;
            init_err <= 1'b0;
            err_code <= 3'd0;
            card_v2  <= 1'b0;
          end
        end
        S_PWRUP, S_GAP: begin
          if (tmr == '0) begin
            state   <= S_SEND;
            bcnt    <= 6'd47;
            SD_CSn  <= 1'b0;
            SD_MOSI <= 1'b0;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_SEND: begin
          if (bcnt == 6'd0) begin
            state   <= S_WAIT;
            tmr     <= TO_LD;
            SD_MOSI <= 1'b1;
          end else begin
            bcnt    <= bcnt - 6'd1;
            SD_MOSI <= word[bcnt - 6'd1];
          end
        end
        S_WAIT: begin
          if (!miso_q) begin
            state <= S_R1;
            sr    <= '0;
            bcnt  <= 6'd6;
          end else if (tmr <= TW'(1)) begin
            tmr      <= '0;
            state    <= S_FAIL;
            SD_CSn   <= 1'b1;
            init_err <= 1'b1;
            err_code <= 3'd1;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_R1: begin
          sr <= {sr[29:0], miso_q};
          if (bcnt != 6'd0) begin
            bcnt <= bcnt - 6'd1;
          end else begin
            unique case (cmd)
              C_0: begin
                if (r1 == 8'h01) begin
                  state  <= S_GAP;
                  cmd    <= C_8;
                  tmr    <= GP_LD;
                  SD_CSn <= 1'b1;
                end else begin
                  state    <= S_FAIL;
                  SD_CSn   <= 1'b1;
                  init_err <= 1'b1;
                  err_code <= 3'd2;
                end
              end
              C_8: begin
                if (r1 == 8'h05) begin
                  card_v2 <= 1'b0;
                  state   <= S_GAP;
                  cmd     <= C_55;
                  tmr     <= GP_LD;
                  SD_CSn  <= 1'b1;
                end else if (r1 == 8'h01) begin
                  state <= S_R7;
                  bcnt  <= 6'd31;
                end else begin
                  state    <= S_FAIL;
                  SD_CSn   <= 1'b1;
                  init_err <= 1'b1;
                  err_code <= 3'd4;
                end
              end
              C_55: begin
                if (r1[7:1] == 7'd0) begin
                  state   <= S_SEND;
                  cmd     <= C_41;
                  bcnt    <= 6'd47;
                  SD_MOSI <= 1'b0;
                end else begin
                  state    <= S_FAIL;
                  SD_CSn   <= 1'b1;
                  init_err <= 1'b1;
                  err_code <= 3'd4;
                end
              end
              C_41: begin
                if (r1 == 8'h00) begin
                  state  <= S_DONE;
                  SD_CSn <= 1'b1;
                  init_o <= 1'b1;
                end else if (r1 == 8'h01 && retry <= RW'(1)) begin
                  retry    <= '0;
                  state    <= S_FAIL;
                  SD_CSn   <= 1'b1;
                  init_err <= 1'b1;
                  err_code <= 3'd5;
                end else if (r1 == 8'h01) begin
                  retry  <= retry - 1'b1;
                  state  <= S_GAP;
                  cmd    <= C_55;
                  tmr    <= GP_LD;
                  SD_CSn <= 1'b1;
                end else begin
                  state    <= S_FAIL;
                  SD_CSn   <= 1'b1;
                  init_err <= 1'b1;
                  err_code <= 3'd4;
                end
              end
              default: state <= S_IDLE;
            endcase
          end
        end
        S_R7: begin
          sr <= {sr[29:0], miso_q};
          if (bcnt != 6'd0) begin
            bcnt <= bcnt - 6'd1;
          end else if (r7[11:0] == 12'h1AA) begin
            card_v2 <= 1'b1;
            state   <= S_GAP;
            cmd     <= C_55;
            tmr     <= GP_LD;
            SD_CSn  <= 1'b1;
          end else begin
            state    <= S_FAIL;
            SD_CSn   <= 1'b1;
            init_err <= 1'b1;
            err_code <= 3'd3;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
